small_tensor_core: RTL and testbench
====================================

SMALL_TENSOR_CORE -- requirements
Module: small_tensor_core

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 4: signed element width.
REQ-002 SHALL have parameter DIM, default 4: square matrix dimension.
REQ-003 SHALL use one clock and an asynchronous, active-high reset, with ports as follows.
- clock_in  input  1: single clock, rising edge.
- reset_in  input  1: asynchronous, active-high reset.
- tensor_core_register_file_write_enable  input  1: operand storage is being written; (re)arms the core.
- tensor_core_input1  input  signed DATA_WIDTH x [DIM][DIM]: matrix A.
- tensor_core_input2  input  signed DATA_WIDTH x [DIM][DIM]: matrix B.
- tensor_core_output  output  signed DATA_WIDTH x [DIM][DIM]: registered result C = A x B.
- is_done_with_calculation  output  1: registered, one-cycle completion pulse.

Function
REQ-004 SHALL keep an internal pending flag: set on any edge with write_enable=1; cleared when a computation starts.
REQ-005 SHALL be an FSM with states IDLE, COMPUTE and DONE.
REQ-006 IDLE: on an edge with pending=1 and write_enable=0, SHALL snapshot A and B, clear pending, set index=0 and go to COMPUTE.
REQ-007 COMPUTE: each edge SHALL write one element C[i][j] = sum over k of A[i][k]*B[k][j], in row-major index order 0..DIM*DIM-1, computed from the snapshot.
REQ-008 After writing the element at index DIM*DIM-1, the FSM SHALL go to DONE. With defaults, the 16th COMPUTE edge writes element 15.
REQ-009 DONE: is_done_with_calculation SHALL be 1 for exactly this one cycle, and the FSM SHALL then return to IDLE.
REQ-010 Done latency SHALL be 16 cycles from the start edge to the first cycle with done=1, with defaults.
REQ-011 Products and sums SHALL be computed at full precision (2*DATA_WIDTH+2 bits) before final reduction to DATA_WIDTH.
REQ-012 Reduction SHALL be two's-complement wrap (keep the low DATA_WIDTH bits) unless TENSOR_CORE_SATURATE_EN is defined.
REQ-013 write_enable=1 in COMPUTE SHALL abort the operation: go to IDLE, set pending, no done pulse, and already-written elements retain their values.
REQ-014 write_enable=1 in DONE SHALL NOT suppress the done pulse; it SHALL set pending.
REQ-015 Unwritten output elements SHALL hold their previous values; outputs change only on COMPUTE edges or reset.
REQ-016 After a computation with no further write, the core SHALL stay IDLE; it SHALL never self-retrigger.

Reset
REQ-017 reset_in=1 SHALL immediately (asynchronously) clear all tensor_core_output elements to 0, done to 0, pending to 0, index to 0, and the snapshot, and SHALL force the FSM to IDLE.
REQ-018 Reset mid-COMPUTE SHALL discard the operation; no done pulse SHALL follow.

Configuration
REQ-019 With TENSOR_CORE_SATURATE_EN defined, each result SHALL clamp to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1], i.e. [-8, 7] with defaults.
REQ-020 Without TENSOR_CORE_SATURATE_EN, results SHALL wrap; timing and all other behaviour are identical in both builds.

Structure
REQ-021 Package tensor_core_pkg SHALL hold DATA_WIDTH/DIM defaults, the element and matrix typedefs, and the FSM state enum.
REQ-022 Sub-module tensor_core_dot_product SHALL compute one DIM-term signed dot product and perform the wrap/saturate reduction; one instance is used, indexed by row i and column j.

Verification
REQ-023 A = identity, B[i][j] = i-j (in range) -> after write/arm, done at cycle 16 and C equals B.
REQ-024 A = B = all 2 -> each element 16: wrap build C = all 0; saturate build C = all 7.
REQ-025 A = all -1, B = all 1 -> C = all -4 in both builds, done pulse exactly one cycle wide.
REQ-026 write_enable pulsed at COMPUTE cycle 5 -> no done at cycle 16; computation restarts after write_enable drops; done 16 cycles later with the new-operand result.
REQ-027 reset_in asserted at COMPUTE cycle 8 -> outputs immediately 0, done never asserts, core IDLE until the next write.

Source files
------------

// File: rtl/tensor_core_pkg.sv
// Shared types and defaults for the small tensor core.
// Element/matrix typedefs and the sequencing FSM state enum.
package tensor_core_pkg;

    localparam int TC_DATA_WIDTH = 4;
    localparam int TC_DIM        = 4;

    typedef logic signed [TC_DATA_WIDTH-1:0] elem_t;
    typedef elem_t [TC_DIM-1:0] vec_t;
    typedef vec_t  [TC_DIM-1:0] mat_t;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPUTE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

endpackage

// File: rtl/tensor_core_dot_product.sv
// One DIM-term signed dot product with reduction to DATA_WIDTH.
// Wraps by default; clamps when TENSOR_CORE_SATURATE_EN is defined.
module tensor_core_dot_product
    import tensor_core_pkg::*;
#(
    parameter int DATA_WIDTH = TC_DATA_WIDTH,
    parameter int DIM        = TC_DIM
) (
    input  logic [DIM-1:0][DATA_WIDTH-1:0] i_row,
    input  logic [DIM-1:0][DATA_WIDTH-1:0] i_col,
    output logic [DATA_WIDTH-1:0]          o_result
);

    localparam int ACC_W = 2*DATA_WIDTH + 2;
    localparam int MAX_I = (2**(DATA_WIDTH-1)) - 1;
    localparam int MIN_I = -(2**(DATA_WIDTH-1));

    logic signed [ACC_W-1:0] w_acc;
    logic signed [ACC_W-1:0] w_prod;

    // Full-precision multiply-accumulate across the row/column pair.
    always_comb begin
        w_acc  = '0;
        w_prod = '0;
        for (int k = 0; k < DIM; k++) begin
            w_prod = ACC_W'($signed(i_row[k])) * ACC_W'($signed(i_col[k]));
            w_acc  = w_acc + w_prod;
        end
    end

`ifdef TENSOR_CORE_SATURATE_EN
    // Clamp to the representable signed range of one element.
    always_comb begin
        if (w_acc > ACC_W'(MAX_I)) begin
            o_result = DATA_WIDTH'(MAX_I);
        end else if (w_acc < ACC_W'(MIN_I)) begin
            o_result = DATA_WIDTH'(MIN_I);
        end else begin
            o_result = w_acc[DATA_WIDTH-1:0];
        end
    end
`else
    logic w_unused_hi;
    assign w_unused_hi = ^{w_acc[ACC_W-1:DATA_WIDTH], MAX_I[0], MIN_I[0]};

    // Two's-complement wrap: keep the low bits only.
    always_comb begin
        o_result = w_acc[DATA_WIDTH-1:0];
    end
`endif

endmodule

// File: rtl/small_tensor_core.sv
// Sequential DIM x DIM signed matrix multiply, one element per cycle.
// Build option: TENSOR_CORE_SATURATE_EN selects clamping over wrap.
module small_tensor_core
    import tensor_core_pkg::*;
#(
    parameter int DATA_WIDTH = TC_DATA_WIDTH,
    parameter int DIM        = TC_DIM
) (
    input  logic                                   clock_in,
    input  logic                                   reset_in,
    input  logic                                   tensor_core_register_file_write_enable,
    input  logic [DIM-1:0][DIM-1:0][DATA_WIDTH-1:0] tensor_core_input1,
    input  logic [DIM-1:0][DIM-1:0][DATA_WIDTH-1:0] tensor_core_input2,
    output logic [DIM-1:0][DIM-1:0][DATA_WIDTH-1:0] tensor_core_output,
    output logic                                   is_done_with_calculation
);

    localparam int IW = $clog2(DIM*DIM);
    localparam int JW = $clog2(DIM);

    state_t r_state;
    state_t w_next;

    logic                                   r_pending;
    logic                                   r_done;
    logic [IW-1:0]                          r_idx;
    logic [DIM-1:0][DIM-1:0][DATA_WIDTH-1:0] r_a;
    logic [DIM-1:0][DIM-1:0][DATA_WIDTH-1:0] r_b;
    logic [DIM-1:0][DIM-1:0][DATA_WIDTH-1:0] r_c;

    logic                          w_we;
    logic                          w_start;
    logic                          w_write;
    logic                          w_last;
    logic [JW-1:0]                 w_i;
    logic [JW-1:0]                 w_j;
    logic [DIM-1:0][DATA_WIDTH-1:0] w_row;
    logic [DIM-1:0][DATA_WIDTH-1:0] w_col;
    logic [DATA_WIDTH-1:0]         w_dot;

    assign w_we   = tensor_core_register_file_write_enable;
    assign w_i    = r_idx[IW-1:JW];
    assign w_j    = r_idx[JW-1:0];
    assign w_last = (r_idx == IW'(DIM*DIM-1));

    assign tensor_core_output       = r_c;
    assign is_done_with_calculation = r_done;

    // Gather row i of A and column j of B for the current element.
    always_comb begin
        w_row = r_a[w_i];
        w_col = '0;
        for (int k = 0; k < DIM; k++) begin
            w_col[k] = r_b[k][w_j];
        end
    end

    tensor_core_dot_product #(
        .DATA_WIDTH(DATA_WIDTH),
        .DIM       (DIM)
    ) u_dot (
        .i_row   (w_row),
        .i_col   (w_col),
        .o_result(w_dot)
    );

    // State register.
    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and per-edge control strobes.
    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        w_write = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (r_pending && !w_we) begin
                    w_next  = S_COMPUTE;
                    w_start = 1'b1;
                end
            end
            S_COMPUTE: begin
                if (w_we) begin
                    w_next = S_IDLE;
                end else begin
                    w_write = 1'b1;
                    if (w_last) begin
                        w_next = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Operand snapshot, element index, pending flag, results and done pulse.
    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            r_pending <= 1'b0;
            r_done    <= 1'b0;
            r_idx     <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_c       <= '0;
        end else begin
            r_done <= w_write && w_last;
            if (w_we) begin
                r_pending <= 1'b1;
            end else if (w_start) begin
                r_pending <= 1'b0;
            end
            if (w_start) begin
                r_a   <= tensor_core_input1;
                r_b   <= tensor_core_input2;
                r_idx <= '0;
            end
            if (w_write) begin
                r_c[w_i][w_j] <= w_dot;
                r_idx         <= r_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_small_tensor_core.sv
// Scoreboard bench for small_tensor_core: random and directed matrices,
// abort and mid-run reset, checked against an arithmetic reference model.
module tb_small_tensor_core;

    localparam int DW   = 4;
    localparam int DIM  = 4;
    localparam int MAXV = (1 << (DW-1)) - 1;
    localparam int MINV = -(1 << (DW-1));

    typedef logic [DIM-1:0][DIM-1:0][DW-1:0] mat_t;
    typedef struct {
        mat_t c;
        int   cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic we;
    mat_t in1;
    mat_t in2;
    mat_t out;
    logic done;

    int   cyc   = 0;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t q[$];
    mat_t last_c;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    small_tensor_core #(
        .DATA_WIDTH(DW),
        .DIM       (DIM)
    ) dut (
        .clock_in                              (clk),
        .reset_in                              (rst),
        .tensor_core_register_file_write_enable(we),
        .tensor_core_input1                    (in1),
        .tensor_core_input2                    (in2),
        .tensor_core_output                    (out),
        .is_done_with_calculation              (done)
    );

    function automatic mat_t model(input mat_t a, input mat_t b);
        mat_t c;
        int   s;
        c = '0;
        for (int i = 0; i < DIM; i++) begin
            for (int j = 0; j < DIM; j++) begin
                s = 0;
                for (int k = 0; k < DIM; k++) begin
                    s += int'($signed(a[i][k])) * int'($signed(b[k][j]));
                end
`ifdef TENSOR_CORE_SATURATE_EN
                if (s > MAXV) s = MAXV;
                else if (s < MINV) s = MINV;
`endif
                c[i][j] = DW'(s);
            end
        end
        return c;
    endfunction

    function automatic mat_t rnd_mat();
        mat_t m;
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++)
                m[i][j] = DW'($urandom);
        return m;
    endfunction

    function automatic mat_t fill(input int v);
        mat_t m;
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++)
                m[i][j] = DW'(v);
        return m;
    endfunction

    // Monitor: every done cycle must match the oldest expected result.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && done) begin
            n_vec++;
            if (q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_done cyc=%0d got done=1 want 0", cyc);
            end else begin
                e = q.pop_front();
                if (e.cyc != cyc) begin
                    n_err++;
                    $display("FAIL done_latency got cyc=%0d want cyc=%0d", cyc, e.cyc);
                end
                n_vec++;
                if (out !== e.c) begin
                    n_err++;
                    $display("FAIL result got %h want %h", out, e.c);
                end
            end
        end
    end

    // Called just after an edge: one-cycle write pulse, then arm expectation.
    task automatic write_op(input mat_t a, input mat_t b, input bit exp_done);
        exp_t e;
        in1 = a;
        in2 = b;
        we  = 1'b1;
        @(posedge clk);
        #1;
        we = 1'b0;
        if (exp_done) begin
            e.c   = model(a, b);
            e.cyc = cyc + 17;
            q.push_back(e);
        end
    endtask

    task automatic wait_done();
        repeat (40) begin
            if (q.size() == 0) break;
            @(negedge clk);
        end
        n_vec++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL no_done outstanding=%0d want 0", q.size());
            q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input mat_t a, input mat_t b);
        write_op(a, b, 1'b1);
        last_c = model(a, b);
        wait_done();
    endtask

    task automatic check_mat(input string nm, input mat_t want);
        n_vec++;
        if (out !== want) begin
            n_err++;
            $display("FAIL %s got %h want %h", nm, out, want);
        end
    endtask

    task automatic check_done0(input string nm);
        n_vec++;
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL %s got done=%b want 0", nm, done);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        mat_t a;
        mat_t b;
        mat_t a2;
        mat_t b2;
        mat_t prev;
        mat_t part;
        mat_t r1;

        rst = 1'b1;
        we  = 1'b0;
        in1 = '0;
        in2 = '0;
        last_c = '0;
        repeat (2) @(posedge clk);
        #1;
        check_mat("reset_out", '0);
        check_done0("reset_done");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Identity times a small signed pattern returns the pattern.
        a = '0;
        b = '0;
        for (int i = 0; i < DIM; i++) begin
            a[i][i] = DW'(1);
            for (int j = 0; j < DIM; j++) b[i][j] = DW'(i - j);
        end
        run_op(a, b);
        check_mat("identity", b);

        // Each sum is 16: wraps to 0 or clamps to 7.
        run_op(fill(2), fill(2));

        // Each sum is -4 in both builds.
        run_op(fill(-1), fill(1));

        // Results hold while idle; no self-retrigger.
        repeat (10) @(posedge clk);
        #1;
        check_mat("idle_hold", last_c);
        check_done0("idle_done");

        for (int t = 0; t < 20; t++) begin
            run_op(rnd_mat(), rnd_mat());
        end

        // Abort on the fifth compute edge, restart with new operands.
        a    = rnd_mat();
        b    = rnd_mat();
        prev = last_c;
        write_op(a, b, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        a2 = rnd_mat();
        b2 = rnd_mat();
        write_op(a2, b2, 1'b1);
        r1   = model(a, b);
        part = prev;
        for (int n = 0; n < 4; n++) begin
            part[n / DIM][n % DIM] = r1[n / DIM][n % DIM];
        end
        check_mat("abort_partial", part);
        last_c = model(a2, b2);
        wait_done();

        // Reset in the middle of a computation.
        write_op(rnd_mat(), rnd_mat(), 1'b0);
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_mat("midreset_out", '0);
        check_done0("midreset_done");
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        check_mat("post_reset_idle", '0);
        last_c = '0;

        for (int t = 0; t < 4; t++) begin
            run_op(rnd_mat(), rnd_mat());
        end
        check_mat("final", last_c);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
